// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: round-robin IFU/LSU arbiter in front of one single-ported memory.
// Rev 1.0 -- one outstanding transaction, optional wait states before each access.
module mem_arbiter #(
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  input  logic        ifu_resp_ready,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic        lsu_req_rw,
  input  logic [1:0]  lsu_req_size,
  input  logic        lsu_req_signed,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  input  logic        lsu_resp_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic        mem_signed,
  input  logic [31:0] mem_rdata
);
  localparam logic       c_MEM_READ   = 1'b0;
  localparam logic       c_MEM_WRITE  = 1'b1;
  localparam logic [1:0] c_SIZE_WORD  = 2'd2;
  localparam logic [3:0] c_WAIT_LAST  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t      r_state;
  owner_t      r_owner;
  owner_t      r_last_grant;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_mem_rw;
  logic [1:0]  r_mem_size;
  logic        r_mem_signed;
  logic [31:0] r_resp_data;
  logic        r_ifu_resp_valid;
  logic        r_lsu_resp_valid;

  logic        w_grant_ifu;
  logic        w_grant_lsu;
  logic        w_idle;
  logic        w_resp_taken;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_rw;
  logic [1:0]  w_sel_size;
  logic        w_sel_signed;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    w_grant_lsu  = lsu_req_valid && (!ifu_req_valid || (r_last_grant == OWN_IFU));
    w_grant_ifu  = ifu_req_valid && !w_grant_lsu;
    w_idle       = (r_state == S_IDLE) && !rst;
    w_resp_taken = (r_owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;
    w_sel_addr   = w_grant_lsu ? lsu_req_addr   : ifu_req_addr;
    w_sel_wdata  = w_grant_lsu ? lsu_req_wdata  : 32'd0;
    w_sel_rw     = w_grant_lsu ? lsu_req_rw     : c_MEM_READ;
    w_sel_size   = w_grant_lsu ? lsu_req_size   : c_SIZE_WORD;
    w_sel_signed = w_grant_lsu ? lsu_req_signed : 1'b0;
  end

  assign ifu_req_ready  = w_idle && w_grant_ifu;
  assign lsu_req_ready  = w_idle && w_grant_lsu;
  assign ifu_resp_valid = r_ifu_resp_valid;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign ifu_resp_data  = r_resp_data;
  assign lsu_resp_data  = r_resp_data;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  // A reset landing on an ACCESS cycle must suppress the write on that same edge.
  assign mem_rw         = r_mem_rw & ~rst;
  assign mem_size       = r_mem_size;
  assign mem_signed     = r_mem_signed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_owner          <= OWN_IFU;
      r_last_grant     <= OWN_IFU;
      r_wait_cnt       <= 4'd0;
      r_addr           <= RESET_ADDR;
      r_wdata          <= 32'd0;
      r_rw             <= c_MEM_READ;
      r_size           <= c_SIZE_WORD;
      r_signed         <= 1'b0;
      r_mem_rw         <= c_MEM_READ;
      r_mem_size       <= c_SIZE_WORD;
      r_mem_signed     <= 1'b0;
      r_resp_data      <= 32'd0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_ifu || w_grant_lsu) begin
            r_owner      <= w_grant_lsu ? OWN_LSU : OWN_IFU;
            r_last_grant <= w_grant_lsu ? OWN_LSU : OWN_IFU;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_rw         <= w_sel_rw;
            r_size       <= w_sel_size;
            r_signed     <= w_sel_signed;
            r_wait_cnt   <= 4'd0;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
            end else begin
              r_state      <= S_ACCESS;
              r_mem_rw     <= w_sel_rw;
              r_mem_size   <= w_sel_size;
              r_mem_signed <= w_sel_signed;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == c_WAIT_LAST) begin
            r_state      <= S_ACCESS;
            r_wait_cnt   <= 4'd0;
            r_mem_rw     <= r_rw;
            r_mem_size   <= r_size;
            r_mem_signed <= r_signed;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          r_resp_data      <= (r_rw == c_MEM_WRITE) ? 32'd0 : mem_rdata;
          r_mem_rw         <= c_MEM_READ;
          r_mem_size       <= c_SIZE_WORD;
          r_mem_signed     <= 1'b0;
          r_ifu_resp_valid <= (r_owner == OWN_IFU);
          r_lsu_resp_valid <= (r_owner == OWN_LSU);
          r_state          <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_taken) begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
